// File: rtl/vx_itr_return_capture_pkg.sv
// Shared types and sizing helpers for the hw-interrupt return-PC capture block.
// Optional feature macro: VX_ITR_RET_TIMEOUT_EN (WAIT timeout and abort).
package vx_itr_return_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WAIT  = 2'd2
    } itr_ret_state_e;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int unsigned log2up(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Counter width large enough for both the delay and the timeout count.
    function automatic int unsigned itr_ret_cnt_w(input int unsigned dly, input int unsigned tmo);
        return log2up(((dly > tmo) ? dly : tmo) + 1);
    endfunction

endpackage

// File: rtl/vx_itr_ret_slot.sv
// One issue-slot tracker: trigger/delay/wait FSM, wid latch and capture register.
// Optional feature macro: VX_ITR_RET_TIMEOUT_EN (WAIT counter and timeout pulse).
module vx_itr_ret_slot
    import vx_itr_return_capture_pkg::*;
#(
    parameter int unsigned WID_W          = 2,
    parameter int unsigned PC_W           = 32,
    parameter int unsigned PC_INC         = 4,
    parameter int unsigned DELAY_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_trig,
    input  logic [WID_W-1:0] i_trig_wid,
    input  logic             i_cmt_valid,
    input  logic             i_cmt_ready,
    input  logic [WID_W-1:0] i_cmt_wid,
    input  logic [PC_W-1:0]  i_cmt_pc,
    output logic             o_ret_valid,
    output logic [PC_W-1:0]  o_ret_pc,
    output logic             o_busy,
    output logic             o_rearm,
    output logic             o_timeout
);

    localparam int unsigned        CNT_W    = itr_ret_cnt_w(DELAY_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    // Loaded with DELAY_CYCLES-1 so that, counting the trigger cycle, commits
    // become eligible exactly DELAY_CYCLES cycles after the trigger.
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'((DELAY_CYCLES > 1) ? DELAY_CYCLES - 1 : 1);
    localparam logic [PC_W-1:0]    PC_ADD   = PC_W'(PC_INC);

    itr_ret_state_e   r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [WID_W-1:0] r_wid, w_wid_n;
    logic [PC_W-1:0]  r_ret_pc, w_ret_pc_n;
    logic             r_ret_valid, w_ret_valid_n;
    logic             r_rearm, w_rearm_n;
    logic             w_fire;

`ifdef VX_ITR_RET_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [CNT_W-1:0] r_wcnt, w_wcnt_n;
    logic             r_timeout, w_timeout_n;
`endif

    assign w_fire      = (r_state == WAIT) & i_cmt_valid & i_cmt_ready & (i_cmt_wid == r_wid);
    assign o_busy      = (r_state != IDLE);
    assign o_ret_valid = r_ret_valid;
    assign o_ret_pc    = r_ret_pc;
    assign o_rearm     = r_rearm;

    // Next-state and capture decisions; a trigger always takes priority over a fire.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_wid_n       = r_wid;
        w_ret_pc_n    = r_ret_pc;
        w_ret_valid_n = 1'b0;
        w_rearm_n     = 1'b0;
`ifdef VX_ITR_RET_TIMEOUT_EN
        w_wcnt_n      = r_wcnt;
        w_timeout_n   = 1'b0;
`endif
        if (i_trig) begin
            w_rearm_n = (r_state != IDLE);
            w_wid_n   = i_trig_wid;
            if (DELAY_CYCLES > 1) begin
                w_state_n = DELAY;
                w_cnt_n   = CNT_LOAD;
            end else begin
                w_state_n = WAIT;
            end
`ifdef VX_ITR_RET_TIMEOUT_EN
            w_wcnt_n = '0;
`endif
        end else begin
            case (r_state)
                DELAY: begin
                    if (r_cnt == CNT_ONE) begin
                        w_state_n = WAIT;
`ifdef VX_ITR_RET_TIMEOUT_EN
                        w_wcnt_n  = '0;
`endif
                    end else begin
                        w_cnt_n = r_cnt - CNT_ONE;
                    end
                end
                WAIT: begin
                    if (w_fire) begin
                        w_state_n     = IDLE;
                        w_ret_pc_n    = i_cmt_pc + PC_ADD;
                        w_ret_valid_n = 1'b1;
                    end
`ifdef VX_ITR_RET_TIMEOUT_EN
                    else if (r_wcnt == TMO_LAST) begin
                        w_state_n   = IDLE;
                        w_timeout_n = 1'b1;
                    end else begin
                        w_wcnt_n = r_wcnt + CNT_ONE;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // State, counter, wid latch and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wid       <= '0;
            r_ret_pc    <= '0;
            r_ret_valid <= 1'b0;
            r_rearm     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_wid       <= w_wid_n;
            r_ret_pc    <= w_ret_pc_n;
            r_ret_valid <= w_ret_valid_n;
            r_rearm     <= w_rearm_n;
        end
    end

`ifdef VX_ITR_RET_TIMEOUT_EN
    // WAIT-cycle counter and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wcnt    <= w_wcnt_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/vx_itr_return_capture.sv
// Per-issue-slot capture of the return PC after a hw-interrupt-entry WSPAWN
// (pc==0, wmask==0). Observes SFU commit handshakes only; never back-pressures.
// Optional feature macro: VX_ITR_RET_TIMEOUT_EN (abort WAIT after TIMEOUT_CYCLES).
module vx_itr_return_capture
    import vx_itr_return_capture_pkg::*;
#(
    parameter int unsigned ISSUE_CNT      = 4,
    parameter int unsigned WARP_CNT       = 4,
    parameter int unsigned WID_W          = log2up(WARP_CNT),
    parameter int unsigned PC_W           = 32,
    parameter int unsigned PC_INC         = 4,
    parameter int unsigned DELAY_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wctl_valid,
    input  logic                    wctl_wspawn,
    input  logic [WID_W-1:0]        wctl_wid,
    input  logic [PC_W-1:0]         wctl_pc,
    input  logic [WARP_CNT-1:0]     wctl_wmask,
    input  logic [ISSUE_CNT-1:0]    cmt_valid,
    input  logic [ISSUE_CNT-1:0]    cmt_ready,
    input  logic [ISSUE_CNT*WID_W-1:0] cmt_wid,
    input  logic [ISSUE_CNT*PC_W-1:0]  cmt_pc,
    output logic [ISSUE_CNT-1:0]    ret_valid,
    output logic [ISSUE_CNT*PC_W-1:0]  ret_pc,
    output logic [ISSUE_CNT-1:0]    busy,
    output logic [ISSUE_CNT-1:0]    rearm,
    output logic [ISSUE_CNT-1:0]    timeout
);

    logic                 w_trig;
    logic [ISSUE_CNT-1:0] w_slot_trig;

    assign w_trig = wctl_valid & wctl_wspawn & (wctl_pc == '0) & ~|wctl_wmask;

    for (genvar g = 0; g < ISSUE_CNT; g++) begin : g_slot
        assign w_slot_trig[g] = w_trig & ((32'(wctl_wid) % 32'(ISSUE_CNT)) == 32'(g));

        vx_itr_ret_slot #(
            .WID_W          (WID_W),
            .PC_W           (PC_W),
            .PC_INC         (PC_INC),
            .DELAY_CYCLES   (DELAY_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slot (
            .clk         (clk),
            .rst_n       (reset_n),
            .i_trig      (w_slot_trig[g]),
            .i_trig_wid  (wctl_wid),
            .i_cmt_valid (cmt_valid[g]),
            .i_cmt_ready (cmt_ready[g]),
            .i_cmt_wid   (cmt_wid[g*WID_W +: WID_W]),
            .i_cmt_pc    (cmt_pc[g*PC_W +: PC_W]),
            .o_ret_valid (ret_valid[g]),
            .o_ret_pc    (ret_pc[g*PC_W +: PC_W]),
            .o_busy      (busy[g]),
            .o_rearm     (rearm[g]),
            .o_timeout   (timeout[g])
        );
    end

endmodule

// File: tb/tb_vx_itr_return_capture.sv
// Self-checking bench for vx_itr_return_capture: directed scenarios plus
// randomized traffic against a cycle-number based reference model.
module tb_vx_itr_return_capture;

    localparam int ISSUE = 4;
    localparam int WARP  = 4;
    localparam int WIDW  = 2;
    localparam int PCW   = 32;
    localparam int PCINC = 4;
    localparam int DLY   = 2;
    localparam int TMO   = 8;
`ifdef VX_ITR_RET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   wctl_valid, wctl_wspawn;
    logic [WIDW-1:0]        wctl_wid;
    logic [PCW-1:0]         wctl_pc;
    logic [WARP-1:0]        wctl_wmask;
    logic [ISSUE-1:0]       cmt_valid, cmt_ready;
    logic [ISSUE*WIDW-1:0]  cmt_wid;
    logic [ISSUE*PCW-1:0]   cmt_pc;
    logic [ISSUE-1:0]       ret_valid, busy, rearm, timeout;
    logic [ISSUE*PCW-1:0]   ret_pc;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a pending capture per slot, its warp and the first
    // cycle number in which a matching commit counts.
    bit                 m_pend [ISSUE];
    logic [WIDW-1:0]    m_wid  [ISSUE];
    int                 m_elig [ISSUE];
    logic [ISSUE-1:0]   e_rv, e_rearm, e_to;
    logic [ISSUE*PCW-1:0] e_pc;

    vx_itr_return_capture #(
        .ISSUE_CNT      (ISSUE),
        .WARP_CNT       (WARP),
        .WID_W          (WIDW),
        .PC_W           (PCW),
        .PC_INC         (PCINC),
        .DELAY_CYCLES   (DLY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wctl_valid  (wctl_valid),
        .wctl_wspawn (wctl_wspawn),
        .wctl_wid    (wctl_wid),
        .wctl_pc     (wctl_pc),
        .wctl_wmask  (wctl_wmask),
        .cmt_valid   (cmt_valid),
        .cmt_ready   (cmt_ready),
        .cmt_wid     (cmt_wid),
        .cmt_pc      (cmt_pc),
        .ret_valid   (ret_valid),
        .ret_pc      (ret_pc),
        .busy        (busy),
        .rearm       (rearm),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [ISSUE-1:0] m_busy();
        logic [ISSUE-1:0] b;
        for (int i = 0; i < ISSUE; i++) b[i] = m_pend[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ISSUE; i++) begin
            m_pend[i] = 1'b0;
            m_wid[i]  = '0;
            m_elig[i] = 0;
        end
        e_rv = '0; e_rearm = '0; e_to = '0; e_pc = '0;
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        bit trig, fire;
        trig = wctl_valid && wctl_wspawn && (wctl_pc == '0) && (wctl_wmask == '0);
        for (int s = 0; s < ISSUE; s++) begin
            e_rv[s] = 1'b0; e_rearm[s] = 1'b0; e_to[s] = 1'b0;
            fire = m_pend[s] && (cyc >= m_elig[s]) && cmt_valid[s] && cmt_ready[s]
                   && (cmt_wid[s*WIDW +: WIDW] == m_wid[s]);
            if (trig && ((int'(wctl_wid) % ISSUE) == s)) begin
                e_rearm[s] = m_pend[s];
                m_pend[s]  = 1'b1;
                m_wid[s]   = wctl_wid;
                m_elig[s]  = cyc + ((DLY == 0) ? 1 : DLY);
            end else if (fire) begin
                e_rv[s] = 1'b1;
                e_pc[s*PCW +: PCW] = PCW'(cmt_pc[s*PCW +: PCW] + PCINC);
                m_pend[s] = 1'b0;
            end else if (TO_EN && m_pend[s] && (cyc == m_elig[s] + TMO - 1)) begin
                e_to[s]   = 1'b1;
                m_pend[s] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        wctl_valid = 1'b0; wctl_wspawn = 1'b0; wctl_wid = '0; wctl_pc = '0; wctl_wmask = '0;
        cmt_valid = '0; cmt_ready = '0; cmt_wid = '0; cmt_pc = '0;
    endtask

    task automatic set_trig(input int w);
        wctl_valid = 1'b1; wctl_wspawn = 1'b1; wctl_wid = WIDW'(w); wctl_pc = '0; wctl_wmask = '0;
    endtask

    task automatic set_cmt(input int s, input int w, input logic rdy, input logic [PCW-1:0] pc);
        cmt_valid[s] = 1'b1; cmt_ready[s] = rdy;
        cmt_wid[s*WIDW +: WIDW] = WIDW'(w);
        cmt_pc[s*PCW +: PCW] = pc;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({ret_valid, busy, rearm, timeout} !== 16'h0 || ret_pc !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got v/b/r/t=%b/%b/%b/%b pc=%h exp all zero", ret_valid, busy, rearm, timeout, ret_pc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_basic();
        set_trig(1); tick();
        idle_inputs(); tick();
        set_cmt(1, 1, 1'b1, 32'h8000_0100); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b0010 || ret_pc[1*PCW +: PCW] !== 32'h8000_0104) begin
            n_err++;
            $display("FAIL basic_capture got rv=%b pc=%h exp rv=0010 pc=80000104", ret_valid, ret_pc[1*PCW +: PCW]);
        end
        tick();
        n_vec++;
        if (ret_valid !== 4'b0000 || busy[1] !== 1'b0 || ret_pc[1*PCW +: PCW] !== 32'h8000_0104) begin
            n_err++;
            $display("FAIL basic_pulse got rv=%b busy=%b pc=%h exp rv=0000 busy1=0 pc held", ret_valid, busy, ret_pc[1*PCW +: PCW]);
        end
    endtask

    task automatic test_delay_ignore();
        set_trig(2); tick();
        idle_inputs(); set_cmt(2, 2, 1'b1, 32'h100); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b0000 || busy[2] !== 1'b1) begin
            n_err++;
            $display("FAIL delay_ignore got rv=%b busy=%b exp rv=0000 busy2=1", ret_valid, busy);
        end
        repeat (3) tick();
        set_cmt(2, 2, 1'b1, 32'h200); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b0100 || ret_pc[2*PCW +: PCW] !== 32'h204) begin
            n_err++;
            $display("FAIL delay_capture got rv=%b pc=%h exp rv=0100 pc=00000204", ret_valid, ret_pc[2*PCW +: PCW]);
        end
    endtask

    task automatic test_nomatch();
        logic [PCW-1:0] pc;
        pc = $urandom;
        set_trig(0); tick();
        idle_inputs(); repeat (3) tick();
        set_cmt(0, 0, 1'b0, 32'h40); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL nomatch_noready got rv=%b busy=%b exp rv0=0 busy0=1", ret_valid, busy);
        end
        set_cmt(0, 3, 1'b1, 32'h44); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL nomatch_wid got rv=%b busy=%b exp rv0=0 busy0=1", ret_valid, busy);
        end
        set_cmt(0, 0, 1'b1, pc); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b0001 || ret_pc[0 +: PCW] !== PCW'(pc + 4)) begin
            n_err++;
            $display("FAIL nomatch_final got rv=%b pc=%h exp rv=0001 pc=%h", ret_valid, ret_pc[0 +: PCW], PCW'(pc + 4));
        end
    endtask

    task automatic test_rearm_collision();
        set_trig(3); tick();
        idle_inputs(); repeat (2) tick();
        set_trig(3); set_cmt(3, 3, 1'b1, 32'h1234); tick();
        idle_inputs();
        n_vec++;
        if (rearm !== 4'b1000 || ret_valid !== 4'b0000 || busy[3] !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_collision got rearm=%b rv=%b busy=%b exp rearm=1000 rv=0000 busy3=1", rearm, ret_valid, busy);
        end
        set_cmt(3, 3, 1'b1, 32'h2000); tick();
        idle_inputs();
        n_vec++;
        if (rearm !== 4'b0000 || ret_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL rearm_restart got rearm=%b rv=%b exp rearm=0000 rv=0000", rearm, ret_valid);
        end
        set_cmt(3, 3, 1'b1, 32'h3000); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b1000 || ret_pc[3*PCW +: PCW] !== 32'h3004) begin
            n_err++;
            $display("FAIL rearm_capture got rv=%b pc=%h exp rv=1000 pc=00003004", ret_valid, ret_pc[3*PCW +: PCW]);
        end
    endtask

    task automatic test_wrap();
        set_trig(0); tick();
        idle_inputs(); tick();
        set_cmt(0, 0, 1'b1, 32'hFFFF_FFFE); tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b0001 || ret_pc[0 +: PCW] !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL wrap got rv=%b pc=%h exp rv=0001 pc=00000002", ret_valid, ret_pc[0 +: PCW]);
        end
    endtask

    task automatic test_back_to_back();
        logic [PCW-1:0] pcs [ISSUE];
        for (int w = 0; w < ISSUE; w++) begin
            set_trig(w); tick();
        end
        idle_inputs(); repeat (2) tick();
        for (int s = 0; s < ISSUE; s++) begin
            pcs[s] = $urandom;
            set_cmt(s, s, 1'b1, pcs[s]);
        end
        tick();
        idle_inputs();
        n_vec++;
        if (ret_valid !== 4'b1111) begin
            n_err++;
            $display("FAIL b2b_valid got rv=%b exp rv=1111", ret_valid);
        end
        for (int s = 0; s < ISSUE; s++) begin
            n_vec++;
            if (ret_pc[s*PCW +: PCW] !== PCW'(pcs[s] + 4)) begin
                n_err++;
                $display("FAIL b2b_pc slot=%0d got %h exp %h", s, ret_pc[s*PCW +: PCW], PCW'(pcs[s] + 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        set_trig(2); tick();
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({ret_valid, busy, rearm, timeout} !== 16'h0 || ret_pc !== '0) begin
            n_err++;
            $display("FAIL reset_mid got v/b/r/t=%b/%b/%b/%b pc=%h exp all zero", ret_valid, busy, rearm, timeout, ret_pc);
        end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) set_cmt(2, 2, 1'b1, 32'h55);
            else idle_inputs();
            tick();
            n_vec++;
            if ({busy, ret_valid, rearm, timeout} !== {m_busy(), e_rv, e_rearm, e_to} || ret_pc !== e_pc) begin
                n_err++;
                $display("FAIL reset_mid_after cyc=%0d got b/v/r/t=%b/%b/%b/%b pc=%h exp %b/%b/%b/%b pc=%h",
                         cyc, busy, ret_valid, rearm, timeout, ret_pc, m_busy(), e_rv, e_rearm, e_to, e_pc);
            end
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        set_trig(1); tick();
        idle_inputs();
        for (int i = 0; i < DLY + TMO + 3; i++) begin
            tick();
            pulses += $countones(timeout);
            n_vec++;
            if ({busy, ret_valid, rearm, timeout} !== {m_busy(), e_rv, e_rearm, e_to}) begin
                n_err++;
                $display("FAIL timeout_model cyc=%0d got b/v/r/t=%b/%b/%b/%b exp %b/%b/%b/%b",
                         cyc, busy, ret_valid, rearm, timeout, m_busy(), e_rv, e_rearm, e_to);
            end
        end
        n_vec++;
        if (pulses !== (TO_EN ? 1 : 0) || busy[1] !== !TO_EN) begin
            n_err++;
            $display("FAIL timeout_count got pulses=%0d busy1=%b exp pulses=%0d busy1=%b", pulses, busy[1], TO_EN ? 1 : 0, !TO_EN);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if ($urandom_range(3) == 0) begin
                wctl_valid  = 1'b1;
                wctl_wspawn = ($urandom_range(5) != 0);
                wctl_wid    = WIDW'($urandom_range(WARP - 1));
                wctl_pc     = ($urandom_range(4) == 0) ? PCW'($urandom) : '0;
                wctl_wmask  = ($urandom_range(4) == 0) ? WARP'($urandom) : '0;
            end
            for (int s = 0; s < ISSUE; s++) begin
                cmt_valid[s] = $urandom_range(1);
                cmt_ready[s] = ($urandom_range(3) != 0);
                cmt_wid[s*WIDW +: WIDW] = ($urandom_range(1) == 0) ? WIDW'(s) : WIDW'($urandom);
                cmt_pc[s*PCW +: PCW] = $urandom;
            end
            tick();
            n_vec++;
            if ({busy, ret_valid, rearm, timeout} !== {m_busy(), e_rv, e_rearm, e_to} || ret_pc !== e_pc) begin
                n_err++;
                $display("FAIL random cyc=%0d got b/v/r/t=%b/%b/%b/%b pc=%h exp %b/%b/%b/%b pc=%h",
                         cyc, busy, ret_valid, rearm, timeout, ret_pc, m_busy(), e_rv, e_rearm, e_to, e_pc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay_ignore();
        test_nomatch();
        test_rearm_collision();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
